instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-issue CPU. It holds the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake. It presents each fetched instruction, its opcode and its PC to the decode/control stage over a valid/ready handshake, and it redirects on branches. It drives the `opcode` that the control unit consumes, and it takes `brnch` from the execute stage.

## Interface
Parameters:
- `XLEN`, 32, width of PC and addresses
- `RESET_PC`, 0, fetch address after reset (must be 4-byte aligned)

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  XLEN  word-aligned read address
- `imem_ack`  in  1  read complete; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `brnch`  in  1  redirect request, one-cycle pulse
- `brnch_tgt`  in  XLEN  redirect target PC
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts the instruction
- `instr`  out  32  fetched instruction
- `opcode`  out  7  equals `instr[6:0]`
- `pc`  out  XLEN  PC of `instr`
- `fetch_err`  out  1  misaligned branch target pulse (`IFETCH_ALIGN_CHK_EN` only)

## Operation
- State register: `pc_fetch` (XLEN). FSM states: FETCH, HOLD, DRAIN.
- Outputs in reset state:
  - `imem_req` = 0
  - `imem_addr` = `RESET_PC`
  - `instr_valid` = 0
  - `instr` = 0x00000013 (NOP), so `opcode` = 0x13
  - `pc` = `RESET_PC`
  - `fetch_err` = 0
  - state = FETCH, `pc_fetch` = `RESET_PC`
- `imem_req` = (state == FETCH || state == DRAIN) && !reset.
- `imem_addr`:
  - in FETCH it equals `pc_fetch`.
  - in DRAIN it equals the address of the outstanding request.
  - It is held stable while `imem_req` is high and `imem_ack` is low.
- FETCH, `imem_ack`=1:
  - capture `instr`←`imem_rdata` and `pc`←`pc_fetch`; set `instr_valid`←1.
  - `pc_fetch`←`pc_fetch`+4, modulo 2^XLEN (wraps at the top of the address space).
  - go to HOLD.
- HOLD: `instr_valid`=1, `imem_req`=0. When `instr_valid && instr_ready`: `instr_valid`←0, go to FETCH.
- `brnch`=1 takes priority over all other transitions:
  - In HOLD: squash (`instr_valid`←0), `pc_fetch`←`brnch_tgt`, go to FETCH. A valid&ready transfer in that same cycle still counts as consumed.
  - In FETCH with `imem_ack`=1: discard `imem_rdata`, `pc_fetch`←`brnch_tgt`, stay in FETCH with the new address next cycle.
  - In FETCH with `imem_ack`=0: `pc_fetch`←`brnch_tgt`, go to DRAIN.
  - In DRAIN: `pc_fetch`←`brnch_tgt` (latest target wins).
- DRAIN: hold the old request until `imem_ack`, discard its data, then go to FETCH.
- Reset in any state returns to the reset values on the next edge. An outstanding memory request is abandoned, and memory must tolerate a dropped request.

## Timing
- Fetch latency: `imem_req` rises in the first cycle with `reset`=0. With a zero-wait memory (ack in the same cycle as req), `instr_valid` rises on the next edge.
- Peak throughput is one instruction per 2 cycles (FETCH, HOLD). Each memory wait cycle adds one cycle.
- Branch to first new request:
  - 1 cycle when `brnch` arrives in HOLD or with an ack.
  - (remaining wait + 1) cycles when `brnch` arrives in DRAIN.
- `instr`, `opcode` and `pc` are stable while `instr_valid`=1 and `instr_ready`=0.
- `instr_ready` while `instr_valid`=0 has no effect.

## Configuration
- `IFETCH_ALIGN_CHK_EN` defined:
  - `brnch` with `brnch_tgt[1:0]` != 0 asserts `fetch_err` for exactly one cycle, on the next edge.
  - The redirect is ignored: no squash, no change to `pc_fetch` or the FSM.
- `IFETCH_ALIGN_CHK_EN` undefined:
  - `fetch_err` is tied to 0.
  - `brnch_tgt[1:0]` is forced to 00 when loaded into `pc_fetch`.

## Test plan
- Reset release, zero-wait memory returning 0x00500093 at address 0, `instr_ready`=1: `imem_addr` = 0, 4, 8; `instr_valid` pulses every 2nd cycle; first `opcode`=0x13, `pc`=0.
- Backpressure: `instr_ready`=0 for 5 cycles after the first fetch. `instr`, `pc` and `instr_valid` are held; `imem_req`=0 throughout; the next fetch is addr 4.
- Branch in HOLD to 0x100 while `instr` at pc 0x8 is held: `instr_valid` drops the next cycle and the next `imem_addr`=0x100.
- Branch to 0x200 while a request to 0x10 waits 3 cycles for ack: `imem_addr` stays 0x10 until ack, the data is discarded with no `instr_valid`, and the next request goes to 0x200.
- `RESET_PC`=0xFFFFFFFC: the second fetch address is 0x00000000.
- With `IFETCH_ALIGN_CHK_EN`, `brnch_tgt`=0x102: `fetch_err`=1 for one cycle and fetch continues sequentially. Without it, the next `imem_addr`=0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: word fetch over req/ack, valid/ready handoff to decode, branch redirect.
// Optional IFETCH_ALIGN_CHK_EN: misaligned branch targets raise fetch_err and are ignored.
module instr_fetch #(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            brnch,
   input  logic [XLEN-1:0] brnch_tgt,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [XLEN-1:0] pc,
   output logic            fetch_err
);

   localparam logic [1:0]  ST_FETCH = 2'd0;
   localparam logic [1:0]  ST_HOLD  = 2'd1;
   localparam logic [1:0]  ST_DRAIN = 2'd2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
   logic [XLEN-1:0] drain_addr_q, drain_addr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            brnch_take_c;
   logic [XLEN-1:0] tgt_c;

`ifdef IFETCH_ALIGN_CHK_EN
   logic fetch_err_q, fetch_err_d;
   logic misalign_c;

   // A misaligned target is reported and otherwise dropped.
   assign misalign_c   = brnch && (brnch_tgt[1:0] != 2'b00);
   assign brnch_take_c = brnch && !misalign_c;
   assign tgt_c        = brnch_tgt;
   assign fetch_err_d  = misalign_c;
   assign fetch_err    = fetch_err_q;

   always_ff @(posedge clock) begin
      if (reset) fetch_err_q <= 1'b0;
      else       fetch_err_q <= fetch_err_d;
   end
`else
   // Low two target bits are cleared so pc_fetch stays word aligned.
   assign brnch_take_c = brnch;
   assign tgt_c        = brnch_tgt & ~XLEN'(3);
   assign fetch_err    = 1'b0;
`endif

   assign imem_req    = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !reset;
   assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_fetch_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign pc          = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_fetch_d   = pc_fetch_q;
      drain_addr_d = drain_addr_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      case (state_q)
         ST_FETCH: begin
            if (brnch_take_c) begin
               pc_fetch_d = tgt_c;
               // Without an ack the old request must still complete before refetching.
               if (!imem_ack) begin
                  drain_addr_d = pc_fetch_q;
                  state_d      = ST_DRAIN;
               end
            end else if (imem_ack) begin
               instr_d    = imem_rdata;
               pc_d       = pc_fetch_q;
               valid_d    = 1'b1;
               pc_fetch_d = pc_fetch_q + XLEN'(4);
               state_d    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (brnch_take_c) begin
               valid_d    = 1'b0;
               pc_fetch_d = tgt_c;
               state_d    = ST_FETCH;
            end else if (instr_ready) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (brnch_take_c) pc_fetch_d = tgt_c;
            if (imem_ack)     state_d    = ST_FETCH;
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_fetch_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         pc_q         <= RESET_PC;
         instr_q      <= NOP;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_fetch_q   <= pc_fetch_d;
         drain_addr_q <= drain_addr_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios, then randomized traffic against a
// transaction-level reference model. Honours IFETCH_ALIGN_CHK_EN if defined.
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, brnch, instr_valid, instr_ready, fetch_err;
   logic [31:0] imem_addr, imem_rdata, brnch_tgt, instr, pc;
   logic [6:0]  opcode;

   logic        imem_req_2, imem_ack_2, brnch_2, instr_valid_2, instr_ready_2, fetch_err_2;
   logic [31:0] imem_addr_2, imem_rdata_2, brnch_tgt_2, instr_2, pc_2;
   logic [6:0]  opcode_2;

   always #5 clock = ~clock;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .brnch(brnch), .brnch_tgt(brnch_tgt),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
      .pc(pc), .fetch_err(fetch_err));

   instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_top (
      .clock(clock), .reset(reset), .imem_req(imem_req_2), .imem_addr(imem_addr_2),
      .imem_ack(imem_ack_2), .imem_rdata(imem_rdata_2), .brnch(brnch_2), .brnch_tgt(brnch_tgt_2),
      .instr_valid(instr_valid_2), .instr_ready(instr_ready_2), .instr(instr_2),
      .opcode(opcode_2), .pc(pc_2), .fetch_err(fetch_err_2));

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   logic        s_reset, s_ready, s_brnch;
   logic [31:0] s_tgt;
   int          lat_fix;
   logic        lat_rand;

   // memory responder
   logic        p_active;
   logic [31:0] p_addr;
   int          wait_left;
   logic [31:0] acked[$];
   logic [31:0] acked2[$];

   // reference model: pending decode word, next fetch address, abandoned in-flight request
   logic        m_valid, m_drop, m_err;
   logic [31:0] m_instr, m_pc, m_next, m_drop_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_drop = 1'b0; m_err = 1'b0;
      m_instr = 32'h13; m_pc = 32'h0; m_next = 32'h0; m_drop_addr = 32'h0;
   endtask

   task automatic model_update(input logic ack, input logic [31:0] rdata);
      logic        take;
      logic [31:0] tgt;
      if (s_reset) begin
         model_reset();
         return;
      end
      take = s_brnch;
`ifdef IFETCH_ALIGN_CHK_EN
      tgt   = s_tgt;
      m_err = s_brnch && (s_tgt[1:0] != 2'b00);
      if (m_err) take = 1'b0;
`else
      tgt   = {s_tgt[31:2], 2'b00};
      m_err = 1'b0;
`endif
      if (m_valid) begin
         if (take) begin
            m_valid = 1'b0;
            m_next  = tgt;
         end else if (s_ready) begin
            m_valid = 1'b0;
         end
      end else if (m_drop) begin
         if (take) m_next = tgt;
         if (ack)  m_drop = 1'b0;
      end else if (take) begin
         if (!ack) begin
            m_drop      = 1'b1;
            m_drop_addr = m_next;
         end
         m_next = tgt;
      end else if (ack) begin
         m_valid = 1'b1;
         m_instr = rdata;
         m_pc    = m_next;
         m_next  = m_next + 32'd4;
      end
   endtask

   // One clock: drive inputs, check outputs against the model, answer memory, advance.
   task automatic step();
      logic exp_req;
      reset       = s_reset;
      instr_ready = s_ready;
      brnch       = s_brnch;
      brnch_tgt   = s_tgt;
      #1;
      exp_req = !m_valid && !s_reset;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_next);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
      chk("opcode", 32'(opcode), 32'(m_instr[6:0]));
      chk("pc", pc, m_pc);
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      if (m_valid && s_ready && !s_reset) chk("accepted_word", instr, mem_word(m_pc));

      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (imem_req) begin
         if (p_active) chk("addr_stable", imem_addr, p_addr);
         else begin
            p_active  = 1'b1;
            wait_left = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
         end
         p_addr = imem_addr;
         if (wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            p_active   = 1'b0;
            if (acked.size() < 8) acked.push_back(imem_addr);
         end else begin
            wait_left--;
         end
      end else begin
         p_active = 1'b0;
      end

      imem_ack_2   = imem_req_2;
      imem_rdata_2 = mem_word(imem_addr_2);
      if (imem_req_2 && acked2.size() < 4) acked2.push_back(imem_addr_2);

      model_update(imem_ack, imem_rdata);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; brnch = 1'b0; brnch_tgt = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      instr_ready_2 = 1'b1; brnch_2 = 1'b0; brnch_tgt_2 = 32'h0;
      imem_ack_2 = 1'b0; imem_rdata_2 = 32'h0;
      s_reset = 1'b1; s_ready = 1'b0; s_brnch = 1'b0; s_tgt = 32'h0;
      lat_fix = 0; lat_rand = 1'b0; p_active = 1'b0; p_addr = 32'h0; wait_left = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;

      // reset values
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_pc", pc, 32'h0);
      chk("rst_err", 32'(fetch_err), 32'h0);
      chk("rst_addr_top", imem_addr_2, 32'hFFFF_FFFC);
      chk("rst_pc_top", pc_2, 32'hFFFF_FFFC);
      chk("rst_valid_top", 32'(instr_valid_2), 32'h0);
      chk("rst_opcode_top", 32'({opcode_2, instr_2[6:0]}), 32'h0993);
      chk("rst_err_top", 32'(fetch_err_2), 32'h0);
      step();

      // zero-wait fetch from reset
      s_reset = 1'b0; s_ready = 1'b1;
      step();
      chk("first_valid", 32'(instr_valid), 32'h1);
      chk("first_opcode", 32'(opcode), 32'h13);
      chk("first_pc", pc, 32'h0);
      chk("first_instr", instr, 32'h0050_0093);

      // backpressure holds the instruction and blocks fetching
      s_ready = 1'b0;
      repeat (5) begin
         step();
         chk("bp_valid", 32'(instr_valid), 32'h1);
         chk("bp_pc", pc, 32'h0);
         chk("bp_instr", instr, 32'h0050_0093);
         chk("bp_req", 32'(imem_req), 32'h0);
      end
      s_ready = 1'b1;
      step();
      chk("bp_next_addr", imem_addr, 32'h4);
      chk("bp_next_req", 32'(imem_req), 32'h1);
      step();
      step();
      step();
      chk("hold_pc8", pc, 32'h8);

      // branch while holding pc 0x8
      s_ready = 1'b0; s_brnch = 1'b1; s_tgt = 32'h100;
      step();
      s_brnch = 1'b0;
      chk("hold_br_valid", 32'(instr_valid), 32'h0);
      chk("hold_br_addr", imem_addr, 32'h100);
      step();

      // redirect to 0x10, then branch to 0x200 while 0x10 waits 3 cycles
      s_brnch = 1'b1; s_tgt = 32'h10;
      step();
      lat_fix = 3; s_tgt = 32'h200;
      step();
      s_brnch = 1'b0;
      chk("drain_addr", imem_addr, 32'h10);
      chk("drain_valid", 32'(instr_valid), 32'h0);
      repeat (2) begin
         step();
         chk("drain_addr", imem_addr, 32'h10);
         chk("drain_valid", 32'(instr_valid), 32'h0);
      end
      step();
      chk("drain_done_valid", 32'(instr_valid), 32'h0);
      chk("drain_done_addr", imem_addr, 32'h200);
      chk("drain_done_req", 32'(imem_req), 32'h1);
      lat_fix = 0;
      step();
      chk("tgt_pc", pc, 32'h200);

      // misaligned target
      s_brnch = 1'b1; s_tgt = 32'h102;
      step();
      s_brnch = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
      chk("mis_err", 32'(fetch_err), 32'h1);
      chk("mis_valid", 32'(instr_valid), 32'h1);
      chk("mis_pc", pc, 32'h200);
      s_ready = 1'b1;
      step();
      chk("mis_err_clr", 32'(fetch_err), 32'h0);
      chk("mis_seq_addr", imem_addr, 32'h204);
`else
      chk("mis_err", 32'(fetch_err), 32'h0);
      chk("mis_valid", 32'(instr_valid), 32'h0);
      chk("mis_addr", imem_addr, 32'h100);
`endif
      s_ready = 1'b1;

      chk("seq_addr0", acked[0], 32'h0);
      chk("seq_addr1", acked[1], 32'h4);
      chk("seq_addr2", acked[2], 32'h8);
      chk("top_addr0", acked2[0], 32'hFFFF_FFFC);
      chk("top_addr1", acked2[1], 32'h0);

      // randomized traffic
      lat_rand = 1'b1;
      repeat (3000) begin
         s_reset = ($urandom_range(0, 99) == 0);
         s_ready = 1'($urandom_range(0, 1));
         s_brnch = ($urandom_range(0, 7) == 0);
         s_tgt   = $urandom;
         if ($urandom_range(0, 3) != 0) s_tgt[1:0] = 2'b00;
         step();
      end
      s_reset = 1'b0; s_brnch = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
